// File: rtl/maze_probe.sv
// maze_probe: converts player position/size into wall probes and looks them up in the tile ROM.
// Define MAZE_PROBE_CORNERS_EN to probe two corner points per direction instead of the centre line.
module maze_probe #(
  parameter int         TILE     = 14,
  parameter int         COLS     = 28,
  parameter int         ROWS     = 31,
  parameter logic [4:0] OOB_CODE = 5'h1F,
  parameter int         ADDR_W   = 10
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [9:0]        BallX,
  input  logic [9:0]        BallY,
  input  logic [9:0]        BallS,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [4:0]        rom_data,
  output logic [4:0]        mapL,
  output logic [4:0]        mapR,
  output logic [4:0]        mapT,
  output logic [4:0]        mapB,
  output logic              busy,
  output logic              done
);
`ifdef MAZE_PROBE_CORNERS_EN
  localparam logic [3:0] NP = 4'd8;
`else
  localparam logic [3:0] NP = 4'd4;
`endif
  localparam logic signed [11:0] T12  = 12'(TILE);
  localparam logic signed [11:0] XLIM = 12'(COLS * TILE);
  localparam logic signed [11:0] YLIM = 12'(ROWS * TILE);
  typedef enum logic [2:0] {IDLE, LATCH, DIVX, DIVY, ADDR, READ, NEXT, DONE} state_t;
  state_t             state, state_n;
  logic [9:0]         bx, by, bs;
  logic [3:0]         idx, k;
  logic [1:0]         kd, d;
  logic signed [11:0] cx, cy, cs, off, kx, ky, rem, ppy;
  logic [5:0]         col, row;
  logic               k_oob, pending, wr;
  logic [4:0]         code;
  logic [4:0]         shadow   [4];
  logic [4:0]         shadow_n [4];
  // k is the probe about to start; in LATCH the inputs are used before they are registered
  always_comb begin
    cx = (state == LATCH) ? {2'b0, BallX} : {2'b0, bx};
    cy = (state == LATCH) ? {2'b0, BallY} : {2'b0, by};
    cs = (state == LATCH) ? {2'b0, BallS} : {2'b0, bs};
    k  = (state == LATCH) ? 4'd0 : idx + 4'd1;
`ifdef MAZE_PROBE_CORNERS_EN
    kd  = k[2:1];
    off = k[0] ? cs - 12'sd1 : 12'sd1 - cs;
    d   = idx[2:1];
    wr  = !idx[0] || shadow[d] == 5'd0;
`else
    kd  = k[1:0];
    off = 12'sd0;
    d   = idx[1:0];
    wr  = 1'b1;
`endif
    kx = cx + ((kd == 2'd0) ? -(cs + 12'sd1) : (kd == 2'd1) ? cs + 12'sd1 : off);
    ky = cy + ((kd == 2'd2) ? -(cs + 12'sd1) : (kd == 2'd3) ? cs + 12'sd1 : off);
    k_oob = kx[11] || ky[11] || kx >= XLIM || ky >= YLIM;
    code = (state == READ) ? rom_data : OOB_CODE;
    shadow_n = shadow;
    if ((state == READ || state == NEXT) && wr) shadow_n[d] = code;
    state_n = state;
    case (state)
      IDLE:              state_n = start ? LATCH : IDLE;
      LATCH, READ, NEXT: state_n = (k == NP) ? DONE : k_oob ? NEXT : DIVX;
      DIVX:              state_n = (rem < T12) ? DIVY : DIVX;
      DIVY:              state_n = (rem < T12) ? ADDR : DIVY;
      ADDR:              state_n = READ;
      DONE:              state_n = (pending || start) ? LATCH : IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      mapL     <= OOB_CODE;
      mapR     <= OOB_CODE;
      mapT     <= OOB_CODE;
      mapB     <= OOB_CODE;
      busy     <= 1'b0;
      done     <= 1'b0;
      rom_addr <= '0;
      pending  <= 1'b0;
    end else begin
      state   <= state_n;
      busy    <= state_n != IDLE && state_n != DONE;
      done    <= state_n == DONE;
      pending <= (state != DONE) && (pending || (start && state != IDLE));
      shadow  <= shadow_n;
      if (state_n == DONE) begin
        mapL <= shadow_n[0];
        mapR <= shadow_n[1];
        mapT <= shadow_n[2];
        mapB <= shadow_n[3];
      end
      if (state == LATCH) begin
        bx <= BallX;
        by <= BallY;
        bs <= BallS;
      end
      if (state == LATCH || state == READ || state == NEXT) begin
        idx <= k;
        rem <= kx;
        ppy <= ky;
        col <= '0;
      end else if (state == DIVX) begin
        if (rem >= T12) begin
          rem <= rem - T12;
          col <= col + 6'd1;
        end else begin
          rem <= ppy;
          row <= '0;
        end
      end else if (state == DIVY && rem >= T12) begin
        rem <= rem - T12;
        row <= row + 6'd1;
      end
      if (state == ADDR) rom_addr <= ADDR_W'(32'(row) * COLS + 32'(col));
    end
  end
endmodule

// File: tb/tb_maze_probe.sv
// tb_maze_probe: randomized and directed checks of maze_probe against a per-transaction behavioural model.
module tb_maze_probe;
`ifdef MAZE_PROBE_CORNERS_EN
  localparam int NP = 8;
`else
  localparam int NP = 4;
`endif
  logic       Clk = 0, Reset, start;
  logic [9:0] BallX, BallY, BallS, rom_addr;
  logic [4:0] rom_data, mapL, mapR, mapT, mapB;
  logic       busy, done;
  logic [4:0] rom [1024];
  assign rom_data = rom[rom_addr];
  maze_probe dut (
    .Clk(Clk), .Reset(Reset), .start(start), .BallX(BallX), .BallY(BallY), .BallS(BallS),
    .rom_addr(rom_addr), .rom_data(rom_data), .mapL(mapL), .mapR(mapR), .mapT(mapT), .mapB(mapB),
    .busy(busy), .done(done)
  );
  always #5 Clk = ~Clk;
  int errors = 0, checks = 0, cyc = 0;
  bit chk_en = 0;
  always @(posedge Clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask
  // model: each transaction is solved outright with integer division, then replayed cycle by cycle
  logic [4:0] m_map [4] = '{default: 5'h1F};
  logic [4:0] res_map [4];
  int  m_addr = 0, m_cnt = 0, res_lat = 0;
  bit  m_busy = 0, m_done = 0, m_active = 0, m_pend = 0;
  int  cyc_q[$];
  function automatic void run_model(input int x, input int y, input int s, input int a0);
    int codes [8];
    int cur;
    cur = a0;
    cyc_q.delete();
    res_lat = 2;
    cyc_q.push_back(cur);
    for (int p = 0; p < NP; p++) begin
      int dd, o, px, py;
      dd = (NP == 8) ? p / 2 : p;
      o  = (NP == 8) ? ((p % 2 == 1) ? s - 1 : 1 - s) : 0;
      px = x + (dd == 0 ? -(s + 1) : dd == 1 ? s + 1 : o);
      py = y + (dd == 2 ? -(s + 1) : dd == 3 ? s + 1 : o);
      if (px < 0 || py < 0 || px >= 28 * 14 || py >= 31 * 14) begin
        codes[p] = 31;
        res_lat += 1;
        cyc_q.push_back(cur);
      end else begin
        int c, r, n;
        c = px / 14;
        r = py / 14;
        n = c + r + 4;
        codes[p] = int'(rom[r * 28 + c]);
        res_lat += n;
        repeat (n - 1) cyc_q.push_back(cur);
        cur = r * 28 + c;
        cyc_q.push_back(cur);
      end
    end
    cyc_q.push_back(cur);
    for (int i = 0; i < 4; i++)
      res_map[i] = 5'((NP == 8) ? (codes[2*i] != 0 ? codes[2*i] : codes[2*i+1]) : codes[i]);
  endfunction
  always @(posedge Clk) begin
    if (Reset) begin
      m_map = '{default: 5'h1F};
      m_busy = 0; m_done = 0; m_active = 0; m_pend = 0; m_addr = 0;
      cyc_q.delete();
    end else begin
      m_done = 0;
      if (m_active) begin
        if (start) m_pend = 1;
        m_addr = cyc_q.pop_front();
        m_cnt--;
        if (m_cnt == 0) begin
          m_active = 0; m_busy = 0; m_done = 1;
          m_map = res_map;
        end
      end else begin
        if (start || m_pend) begin
          run_model(int'(BallX), int'(BallY), int'(BallS), m_addr);
          m_active = 1; m_busy = 1;
          m_cnt = res_lat - 1;
          m_addr = cyc_q.pop_front();
        end
        m_pend = 0;
      end
    end
  end
  always @(negedge Clk) if (chk_en) begin
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("mapL", mapL, m_map[0]);
    chk("mapR", mapR, m_map[1]);
    chk("mapT", mapT, m_map[2]);
    chk("mapB", mapB, m_map[3]);
    chk("rom_addr", rom_addr, m_addr);
  end
  int obs[$];
  task automatic tick(input int n);
    repeat (n) begin @(posedge Clk); #1; end
  endtask
  task automatic pulse;
    start = 1; tick(1); start = 0;
  endtask
  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 3000) begin tick(1); n++; end
    chk(name, done, 1);
  endtask
  task automatic wait_idle;
    int n = 0;
    while ((busy || done) && n < 5000) begin tick(1); n++; end
    chk("idle_reached", busy | done, 0);
  endtask
  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin tick(1); if (done) cnt++; end
  endtask
  task automatic run_txn(input int x, input int y, input int s, output int lat);
    int n = 0, t0, last;
    BallX = 10'(x); BallY = 10'(y); BallS = 10'(s);
    obs.delete();
    last = int'(rom_addr);
    t0 = cyc;
    pulse();
    while (!done && n < 3000) begin
      if (int'(rom_addr) != last) begin last = int'(rom_addr); obs.push_back(last); end
      tick(1); n++;
    end
    chk("txn_done_seen", done, 1);
    lat = cyc - t0;
  endtask
  initial begin
    int lat, cnt;
    int exp_a [4] = '{517, 519, 490, 546};
    Reset = 1; start = 0; BallX = 0; BallY = 0; BallS = 0;
    for (int a = 0; a < 1024; a++) rom[a] = 5'd0;
    tick(2);
    chk_en = 1;
    Reset = 0;
    chk("rst_mapL", mapL, 'h1F);
    chk("rst_mapB", mapB, 'h1F);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", rom_addr, 0);
    tick(2);
`ifdef MAZE_PROBE_CORNERS_EN
    rom[489] = 5'd9;
    run_txn(202, 253, 13, lat);
    chk("corner_lat", lat, 288);
    chk("corner_model_lat", res_lat, 288);
    chk("corner_mapL", mapL, 9);
    chk("corner_mapR", mapR, 0);
    chk("corner_mapT", mapT, 0);
    chk("corner_mapB", mapB, 0);
    rom[489] = 5'd0;
`else
    rom[519] = 5'd3;
    run_txn(202, 253, 13, lat);
    chk("A_lat", lat, 146);
    chk("A_model_lat", res_lat, 146);
    chk("A_naddr", obs.size(), 4);
    for (int i = 0; i < 4 && i < obs.size(); i++) chk("A_addr", obs[i], exp_a[i]);
    chk("A_mapL", mapL, 0);
    chk("A_mapR", mapR, 3);
    chk("A_mapT", mapT, 0);
    chk("A_mapB", mapB, 0);
    rom[519] = 5'd0;
`endif
    tick(2);
    rom[393] = 5'd7;
    run_txn(10, 200, 13, lat);
    chk("B_mapL_oob", mapL, 'h1F);
`ifndef MAZE_PROBE_CORNERS_EN
    chk("B_mapR", mapR, 7);
    chk("B_lat", lat, 58);
    chk("B_naddr", obs.size(), 3);
    if (obs.size() > 0) chk("B_first_addr", obs[0], 393);
`endif
    rom[393] = 5'd0;
    tick(2);
    BallX = 50; BallY = 50; BallS = 5;
    pulse();
    tick(5);
    pulse();
    wait_done("pend_done1");
    pulse();
    chk("rerun_busy", busy, 1);
    wait_done("pend_done2");
    count_done(400, cnt);
    chk("pend_extra_done", cnt, 0);
    BallX = 202; BallY = 253; BallS = 13;
    pulse();
    tick(20);
    Reset = 1; tick(1); Reset = 0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_mapL", mapL, 'h1F);
    chk("abort_mapT", mapT, 'h1F);
    count_done(300, cnt);
    chk("abort_no_done", cnt, 0);
    run_txn(202, 253, 13, lat);
    chk("after_abort_lat", lat, (NP == 8) ? 288 : 146);
    tick(2);
    for (int it = 0; it < 40; it++) begin
      for (int a = 0; a < 1024; a++) rom[a] = ($urandom_range(0, 9) < 6) ? 5'd0 : 5'($urandom_range(1, 31));
      BallX = 10'($urandom_range(0, 420));
      BallY = 10'($urandom_range(0, 460));
      BallS = 10'($urandom_range(0, 20));
      pulse();
      if ($urandom_range(0, 2) == 0) begin
        tick($urandom_range(1, 40));
        pulse();
      end
      wait_idle();
      tick(1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
